seg7_scan_driver: RTL

Time-multiplexed 4-digit 7-segment display driver. It consumes the 16-bit packed BCD score from the binary-to-BCD converter and drives the board's common-anode display. It sits directly downstream of that converter, at the top-level I/O boundary. Features: a snapshot register to prevent mid-frame tearing, leading-zero blanking, a dash for invalid nibbles, per-digit decimal points and a global blank control.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_scan_driver_bcd_to_seg7.sv | 23 ++
 rtl/seg7_scan_driver.sv | 82 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared digit count, active-high segment patterns ({g,f,e,d,c,b,a}) and pattern type
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_0    = 7'h3F;
  localparam seg7_t SEG_1    = 7'h06;
  localparam seg7_t SEG_2    = 7'h5B;
  localparam seg7_t SEG_3    = 7'h4F;
  localparam seg7_t SEG_4    = 7'h66;
  localparam seg7_t SEG_5    = 7'h6D;
  localparam seg7_t SEG_6    = 7'h7D;
  localparam seg7_t SEG_7    = 7'h07;
  localparam seg7_t SEG_8    = 7'h7F;
  localparam seg7_t SEG_9    = 7'h6F;
  localparam seg7_t SEG_DASH = 7'h40;
  localparam seg7_t SEG_OFF  = 7'h00;
endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// bcd_to_seg7: nibble in -> active-high 7-segment pattern out; A..F show a dash
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg7_t      pat
);
  always_comb begin
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 4-digit 7-segment driver with per-frame BCD snapshot
// ports: clk/rst (sync, active-high); bcd, lzb_en, dp_en, blank in; seg, dp, an, frame_start out (registered)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        lzb_en,
  input  logic [3:0]  dp_en,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          frame_start_q, frame_start_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          tick;
  logic [3:0]    nib;
  seg7_t         pat;
  logic [3:0]    lz;
  logic          blk;
  logic [3:0]    an_act;
  seg7_t         seg_act;
  logic          dp_act;
  bcd_to_seg7 u_dec (.nib(nib), .pat(pat));
  always_comb begin
    tick          = cnt_q == CW'(REFRESH_DIV - 1);
    cnt_d         = tick ? '0 : cnt_q + CW'(1);
    idx_d         = tick ? idx_q + IW'(1) : idx_q;
    frame_start_d = tick && idx_q == IW'(NUM_DIGITS - 1);
    snap_d        = frame_start_d ? bcd : snap_q;
    nib           = snap_q[{idx_q, 2'b00} +: 4];
    // lz[k]: nibbles k..3 all zero; digit 0 is never blanked so a zero value still shows "0"
    lz[3]         = lzb_en && snap_q[15:12] == 4'h0;
    lz[2]         = lz[3] && snap_q[11:8] == 4'h0;
    lz[1]         = lz[2] && snap_q[7:4] == 4'h0;
    lz[0]         = 1'b0;
    blk           = lz[idx_q];
    an_act        = (blank || blk) ? 4'h0 : 4'h1 << idx_q;
    seg_act       = blk ? SEG_OFF : pat;
    dp_act        = dp_en[idx_q] && !blk;
    an_d          = AN_ACTIVE_LOW ? ~an_act : an_act;
    seg_d         = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    dp_d          = SEG_ACTIVE_LOW ? !dp_act : dp_act;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_q        <= 16'h0000;
      frame_start_q <= 1'b0;
      an_q          <= AN_ACTIVE_LOW ? 4'hF : 4'h0;
      seg_q         <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
      dp_q          <= SEG_ACTIVE_LOW;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
endmodule
